// File: rtl/cache_traffic_checker.sv
// Cache traffic checker: drives sequential/random write and read traffic at a
// cache request port and checks every read against a shadow copy of the writes.
module cache_traffic_checker #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned IDX_W        = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned RAND_OPS     = 48,
  parameter int unsigned QUIET_CYCLES = 16,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        miss,
  output logic [31:0] addr,
  output logic        rd_req,
  output logic        wr_req,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [31:0] first_err_addr,
  output logic [31:0] stall_cnt
);

  localparam int unsigned DEPTH     = 1 << IDX_W;
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SEQ_WR, S_RAND, S_QUIET, S_SEQ_RD, S_FLUSH, S_DONE
  } state_t;

  // Empty RAND or QUIET phases are skipped rather than run for one cycle.
  localparam state_t AFTER_RAND = (QUIET_CYCLES != 0) ? S_QUIET : S_SEQ_RD;
  localparam state_t AFTER_WR   = (RAND_OPS != 0) ? S_RAND : AFTER_RAND;

  state_t            state, state_n;
  logic [15:0]       lfsr, lfsr_step;
  logic [31:0]       cnt, tmo_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              cmp_pend;
  logic [31:0]       cmp_exp, cmp_addr;
  logic              req, fire, stall, tmo_hit, start_ok, entering_done;

  always_comb begin
    lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0);
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    idx       = '0;
    wdat      = '0;
    case (state)
      S_SEQ_WR: begin
        wr_req = 1'b1;
        idx    = cnt[IDX_W-1:0];
        wdat   = DATA_W'(lfsr);
      end
      S_RAND: begin
        wr_req = lfsr[15];
        rd_req = ~lfsr[15];
        idx    = lfsr[IDX_W-1:0];
        wdat   = DATA_W'(lfsr_step);
      end
      S_SEQ_RD: begin
        rd_req = 1'b1;
        idx    = cnt[IDX_W-1:0];
      end
      default: ;
    endcase

    req     = rd_req | wr_req;
    fire    = req & ~miss;
    stall   = req & miss;
    addr    = req ? BASE_ADDR + (32'(idx) << 2) : '0;
    wr_data = '0;
    if (wr_req) wr_data[DATA_W-1:0] = wdat;

    start_ok = start & ((state == S_IDLE) || (state == S_DONE));
    tmo_hit  = stall & (tmo_cnt == TIMEOUT - 1);

    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_SEQ_WR;
      S_SEQ_WR:       if (fire && cnt == DEPTH - 1) state_n = AFTER_WR;
      S_RAND:         if (fire && cnt == RAND_OPS - 1) state_n = AFTER_RAND;
      S_QUIET:        if (cnt == QUIET_CYCLES - 1) state_n = S_SEQ_RD;
      S_SEQ_RD:       if (fire && cnt == DEPTH - 1) state_n = S_FLUSH;
      // Wait until the last read's compare has updated err_cnt.
      S_FLUSH:        if (!cmp_pend) state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
    if (tmo_hit) state_n = S_DONE;

    entering_done = (state_n == S_DONE) && (state != S_DONE);
    busy          = (state != S_IDLE) && (state != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr           <= SEED_EFF;
      cnt            <= '0;
      tmo_cnt        <= '0;
      cmp_pend       <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      stall_cnt      <= '0;
    end else begin
      if (state_n != state)              cnt <= '0;
      else if (fire || state == S_QUIET) cnt <= cnt + 1;

      if (fire || start_ok) tmo_cnt <= '0;
      else if (stall)       tmo_cnt <= tmo_cnt + 1;

      cmp_pend <= fire & rd_req;
      if (fire && rd_req) begin
        cmp_exp  <= 32'(shadow[idx]);
        cmp_addr <= addr;
      end

      if (start_ok) begin
        lfsr           <= SEED_EFF;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        stall_cnt      <= '0;
      end else begin
        if (fire && (state == S_SEQ_WR || state == S_RAND)) lfsr <= lfsr_step;
        if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1;
        if (cmp_pend && ((rd_data & DATA_MASK) != cmp_exp)) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1;
          if (err_cnt == '0) first_err_addr <= cmp_addr;
        end
        if (entering_done) begin
          done    <= 1'b1;
          timeout <= tmo_hit;
          pass    <= !tmo_hit && (err_cnt == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire && wr_req) shadow[idx] <= wdat;
  end

endmodule
